// File: rtl/bus_responder.sv
// bus_responder: wait-stated CPU bus slave with RAM, output port, status, opcode counter and vectors.
module bus_responder #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] RESET_VEC   = 16'hF000,
  parameter logic [15:0] IRQ_VEC     = 16'hF000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic        i_sync,
  input  logic [7:0]  i_cpu_dout,
  output logic [7:0]  o_cpu_din,
  output logic        o_rdy,
  output logic [7:0]  o_port_out,
  output logic [15:0] o_insn_count
);
  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES - 1);
  logic [7:0]  r_ram [32];
  logic        r_rdy;
  logic [2:0]  r_cnt;
  logic [7:0]  r_din;
  logic [7:0]  r_port;
  logic [15:0] r_insn_count;
  logic        w_wr;
  logic        w_fetch;
  logic        w_ram_sel;
  logic [15:0] w_vec;
  logic [7:0]  w_vec_byte;
  logic [7:0]  w_rd_data;
  assign w_wr       = r_rdy & ~i_rw;
  assign w_fetch    = r_rdy & i_rw & i_sync;
  assign w_ram_sel  = i_address[15:5] == 11'd0;
  // $FFFC/$FFFD is the reset vector; $FFFA/$FFFB and $FFFE/$FFFF both return IRQ_VEC
  assign w_vec      = (i_address[2:1] == 2'b10) ? RESET_VEC : IRQ_VEC;
  assign w_vec_byte = i_address[0] ? w_vec[15:8] : w_vec[7:0];
  assign w_rd_data  = w_ram_sel               ? r_ram[i_address[4:0]] :
                      i_address == 16'hD000   ? r_port :
                      i_address == 16'hD001   ? {7'b0, r_rdy} :
                      i_address == 16'hD002   ? r_insn_count[7:0] :
                      i_address == 16'hD003   ? r_insn_count[15:8] :
                      i_address >= 16'hFFFA   ? w_vec_byte : 8'hEA;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdy        <= 1'b0;
      r_cnt        <= CNT_INIT;
      r_din        <= 8'h00;
      r_port       <= 8'h00;
      r_insn_count <= 16'h0000;
      for (int i = 0; i < 32; i++) r_ram[i] <= 8'h00;
    end else begin
      if (r_rdy) begin
        r_rdy <= 1'b0;
        r_cnt <= CNT_INIT;
      end else if (r_cnt == 3'd0) r_rdy <= 1'b1;
      else r_cnt <= r_cnt - 3'd1;
      if (i_rw) r_din <= w_rd_data;
      if (w_wr && w_ram_sel) r_ram[i_address[4:0]] <= i_cpu_dout;
      if (w_wr && i_address == 16'hD000) r_port <= i_cpu_dout;
      if (w_wr && i_address == 16'hD002) r_insn_count <= 16'h0000;
      else if (w_fetch) r_insn_count <= r_insn_count + 16'd1;
    end
  end
  assign o_cpu_din    = r_din;
  assign o_rdy        = r_rdy;
  assign o_port_out   = r_port;
  assign o_insn_count = r_insn_count;
endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WAIT_CYCLES, default 1, legal range 1..7: number of RDY-low cycles inserted before each access completes.
REQ-003 Parameter RESET_VEC, default 16'hF000: value returned at $FFFC/$FFFD.
REQ-004 Parameter IRQ_VEC, default 16'hF000: value returned at $FFFE/$FFFF and at $FFFA/$FFFB.
REQ-005 CLK  in  1  block clock, shared with the CPU.
REQ-006 RST  in  1  synchronous reset, active high.
REQ-007 ADDRESS  in  16  CPU address bus.
REQ-008 RW  in  1  1 = CPU read, 0 = CPU write.
REQ-009 SYNC  in  1  CPU opcode-fetch indicator.
REQ-010 CPU_DOUT  in  8  write data driven by the CPU.
REQ-011 CPU_DIN  out  8  read data presented to the CPU.
REQ-012 RDY  out  1  access-complete / wait-state control to the CPU.
REQ-013 PORT_OUT  out  8  general-purpose output latch.
REQ-014 INSN_COUNT  out  16  count of completed opcode fetches.

Function
REQ-015 Memory map:
- $0000-$001F: 32x8 RAM, read/write.
- $D000: PORT_OUT latch, read/write.
- $D001: status, read-only, value {7'b0, RDY}.
- $D002: INSN_COUNT[7:0], read-only; any write clears INSN_COUNT.
- $D003: INSN_COUNT[15:8], read-only.
- $FFFA-$FFFF: vectors, little-endian; low byte at the even address.
- All other addresses read $EA; writes to them are ignored.
REQ-016 Wait-state counter cnt (3 bits) SHALL behave as follows.
- If RDY=1 in a cycle: next RDY=0 and cnt=WAIT_CYCLES-1.
- Else if cnt=0: next RDY=1.
- Else: cnt decrements by 1.
REQ-017 Result of REQ-016: RDY is low for exactly WAIT_CYCLES cycles, then high for one cycle; the period is WAIT_CYCLES+1.
REQ-018 A cycle with RDY=1 SHALL be a completed access; the CPU holds ADDRESS, RW and CPU_DOUT stable while RDY=0.
REQ-019 CPU_DIN SHALL be registered: on every edge with RW=1 it loads the decode of the current ADDRESS; with RW=0 it holds its value.
REQ-020 As a consequence of REQ-019, data is valid in the RDY=1 cycle, one cycle of latency from address decode.
REQ-021 A write SHALL commit only on the edge ending a completed cycle with RW=0; writes during RDY=0 cycles have no effect.
REQ-022 INSN_COUNT SHALL increment by 1 on the edge ending a completed cycle with SYNC=1 and RW=1, wrapping from $FFFF to $0000.
REQ-023 A completed write to $D002 SHALL load INSN_COUNT to 0 and takes priority over the increment in the same cycle.
REQ-024 A RAM read following a completed write to the same address SHALL return the new data; there is no stale read path.
REQ-025 Writes to $D001, $D003, $FFFA-$FFFF and unmapped addresses SHALL leave all state unchanged.
REQ-026 An address change while RDY=0 SHALL have no effect on state; CPU_DIN tracks the latest address.
REQ-027 Illegal WAIT_CYCLES values (0 or >7) are outside the contract; 0 SHALL NOT be supported.

Reset
REQ-028 While RST=1 at an edge, the next state SHALL be:
- RDY=0 and cnt=WAIT_CYCLES-1.
- CPU_DIN=0, PORT_OUT=0, INSN_COUNT=0.
- All 32 RAM bytes = 0.
REQ-029 Reset asserted mid-access SHALL abort that access: no write commit and no count increment on that edge.
REQ-030 After RST deasserts, RDY SHALL be low for WAIT_CYCLES cycles, then high.

Verification
REQ-031 Reset timing: WAIT_CYCLES=3, release RST -> RDY low for 3 cycles, high for 1, low for 3, repeating; all outputs 0 while reset is held.
REQ-032 RAM read-after-write: write $5A to $0011 in a completed cycle, then read $0011 -> CPU_DIN=$5A in the RDY=1 cycle; read $0020 -> $EA.
REQ-033 Vectors and port: read $FFFC then $FFFD -> $00 then $F0 (default RESET_VEC); write $C3 to $D000 -> PORT_OUT=$C3 after the completing edge, not before.
REQ-034 Opcode counter: 5 completed cycles with SYNC=1 and 3 with SYNC=0 -> INSN_COUNT=5; preload to $FFFF, then one SYNC fetch -> $0000; write to $D002 -> 0.
REQ-035 Reset mid-write: RW=0 to $0003 with data $77, assert RST during the RDY=0 cycles -> $0003 reads $00 afterwards.
